// File: rtl/wakeup_scheduler_pkg.sv
// Shared constants for the wakeup scheduler: default delay-word width,
// timeout slack and the FSM state encodings.
package wakeup_scheduler_pkg;

    // Default width of the one-hot delay word sent downstream.
    localparam int DLAY_LEN_DEFAULT = 8;

    // Extra WAIT cycles tolerated beyond DLAY_LEN before a timeout.
    localparam int TIMEOUT_SLACK = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10
    } sched_state_t;

endpackage

// File: rtl/wakeup_scheduler_if.sv
// Request handshake and downstream delay-stage signals of the wakeup
// scheduler. The slave side is the scheduler; the master side is the
// requester plus the downstream delay-wakeup stage.
interface wakeup_scheduler_if
    import wakeup_scheduler_pkg::*;
#(
    parameter int DLAY_LEN = DLAY_LEN_DEFAULT
);
    logic                        req_valid;
    logic [$clog2(DLAY_LEN)-1:0] req_dly;
    logic                        req_ready;
    logic [DLAY_LEN-1:0]         wdy;
    logic                        wdy_load;
    logic                        wake_valid;

    modport master (
        output req_valid,
        output req_dly,
        input  req_ready,
        input  wdy,
        input  wdy_load,
        output wake_valid
    );

    modport slave (
        input  req_valid,
        input  req_dly,
        output req_ready,
        output wdy,
        output wdy_load,
        input  wake_valid
    );
endinterface

// File: rtl/wakeup_req_fifo.sv
// Request FIFO of the wakeup scheduler: power-of-two depth, pointer
// wrap by natural overflow, occupancy counter. Pushes at full and pops
// when empty are ignored.
module wakeup_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && (level != FULL_LEVEL);
    assign do_pop   = pop && (level != '0);
    assign empty    = (level == '0);
    assign pop_data = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop keeps the level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/wakeup_scheduler.sv
// Wakeup scheduler top: queues delay requests, issues each one to the
// downstream delay-wakeup stage as a one-hot word with a load strobe,
// and waits for the stage's wakeup before issuing the next.
// Optional feature: define WAKEUP_SCHED_TIMEOUT_EN to build a WAIT
// timeout that raises the sticky err flag and abandons the request.
module wakeup_scheduler
    import wakeup_scheduler_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int DLAY_LEN = DLAY_LEN_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    wakeup_scheduler_if.slave      bus,
    output logic                   done,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level,
    output logic                   err
);
    localparam int DW = $clog2(DLAY_LEN);
    localparam logic [$clog2(DEPTH):0] FULL_LEVEL = ($clog2(DEPTH)+1)'(DEPTH);
    localparam logic [DW:0] DLY_MAX = (DW+1)'(DLAY_LEN - 1);
    localparam logic [DLAY_LEN-1:0] ONE_HOT_BASE = {{(DLAY_LEN-1){1'b0}}, 1'b1};

    sched_state_t  state;
    sched_state_t  state_next;
    logic [DW:0]   dly_wide;
    logic [DW-1:0] dly_sat;
    logic [DW-1:0] head_dly;
    logic          fifo_empty;
    logic          fifo_pop;
    logic          wake_hit;
    logic          timeout_hit;

    assign dly_wide      = {1'b0, bus.req_dly};
    assign dly_sat       = (dly_wide > DLY_MAX) ? DLY_MAX[DW-1:0] : bus.req_dly;
    assign bus.req_ready = (level != FULL_LEVEL);
    assign bus.wdy_load  = (state == ISSUE);
    assign busy          = (state != IDLE) || !fifo_empty;

    wakeup_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DW)
    ) u_req_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.req_valid),
        .push_data (dly_sat),
        .pop       (fifo_pop),
        .pop_data  (head_dly),
        .level     (level),
        .empty     (fifo_empty)
    );

`ifdef WAKEUP_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(DLAY_LEN + TIMEOUT_SLACK + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(DLAY_LEN + TIMEOUT_SLACK - 1);

    logic [CW-1:0] wait_cnt;

    assign timeout_hit = (state == WAIT) && !bus.wake_valid && (wait_cnt == TO_LAST);

    // Count WAIT cycles and latch a sticky error when the wakeup never comes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (state != WAIT) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (timeout_hit) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: pop the head from IDLE, strobe once, then wait.
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        wake_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = ISSUE;
                    fifo_pop   = 1'b1;
                end
            end
            ISSUE: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (bus.wake_valid) begin
                    state_next = IDLE;
                    wake_hit   = 1'b1;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Delay word held from issue until the FSM leaves WAIT; done follows a wakeup.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.wdy <= '0;
            done    <= 1'b0;
        end else begin
            done <= wake_hit;
            if (fifo_pop) begin
                bus.wdy <= ONE_HOT_BASE << head_dly;
            end else if (state_next == IDLE) begin
                bus.wdy <= '0;
            end
        end
    end
endmodule
